baccarat_dealer: RTL and testbench
==================================

BACCARAT_DEALER -- requirements
Module: baccarat_dealer

Interface
REQ-001 slow_clock  input  1  sole clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on slow_clock rising edge.
REQ-003 step  input  1  single-cycle advance pulse, already synchronised and edge-detected upstream.
REQ-004 pscore  input  4  player total (0-9) from external scorehand on pcard1..3.
REQ-005 dscore  input  4  dealer total (0-9) from external scorehand on dcard1..3.
REQ-006 pcard1, pcard2, pcard3  output  4 each  player card registers; 0 = no card, 1-13 = A..K.
REQ-007 dcard1, dcard2, dcard3  output  4 each  dealer card registers; same encoding.
REQ-008 done  output  1  high while in DONE.
REQ-009 player_win, dealer_win  output  1 each  result flags; both high = tie.

Function
REQ-010 Card source: free-running counter, 1..13, +1 every slow_clock, 13 wraps to 1, independent of step.
REQ-011 States: DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, DECIDE_P, DEAL_P3, DECIDE_D, DEAL_D3, DONE.
REQ-012 DEAL_* states: on step, load current source value into the named card register and advance; without step, hold.
REQ-013 Order: DEAL_P1->DEAL_D1->DEAL_P2->DEAL_D2->DECIDE_P.
REQ-014 DECIDE_P: one cycle, step-independent; pscore/dscore reflect four cards here.
REQ-015 DECIDE_P: pscore or dscore in {8,9} -> DONE (natural).
REQ-016 DECIDE_P: else pscore 0-5 -> DEAL_P3.
REQ-017 DECIDE_P: else (pscore 6-7) dscore 0-5 -> DEAL_D3, dscore 6-7 -> DONE.
REQ-018 DECIDE_D: one cycle after DEAL_P3 load, step-independent; v = value of pcard3 (10/J/Q/K = 0, else face).
REQ-019 DECIDE_D dealer draws (->DEAL_D3) when: dscore 0-2 any v; 3 and v!=8; 4 and v in 2-7; 5 and v in 4-7; 6 and v in 6-7; else ->DONE.
REQ-020 DEAL_D3: on step load dcard3, ->DONE.
REQ-021 step in DECIDE_P or DECIDE_D: ignored, no card loaded.
REQ-022 DONE: done=1; player_win = pscore>dscore or equal; dealer_win = dscore>pscore or equal (combinational from state and scores, 0 outside DONE).
REQ-023 DONE + step: all six card registers cleared to 0 and state -> DEAL_P1 on same edge; no card loaded that edge.
REQ-024 Card registers change only on their own load edge, a DONE+step clear, or reset.
REQ-025 At most one card register written per edge.

Reset
REQ-026 reset high: all card registers 0, state DEAL_P1, card source 1, done/player_win/dealer_win 0 next cycle.
REQ-027 reset has priority over step and mid-round state; round abandoned, no partial load.

Structure
REQ-028 Shared package: state enum, CARD_NONE=0, CARD_MIN=1, CARD_MAX=13, NATURAL_MIN=8, PLAYER_STAND_MIN=6.
REQ-029 Card source is sub-module deal_card (slow_clock, reset -> 4-bit card); FSM and card registers in baccarat_dealer.
REQ-030 Third-card value mapping and dealer draw table are combinational functions in baccarat_dealer.

Verification
REQ-031 Reset, then step when source=3 -> pcard1=3, all others 0, state DEAL_D1; source=1 on cycle after reset.
REQ-032 Four steps, bench drives pscore=9, dscore=4 -> DONE after DECIDE_P, pcard3=dcard3=0, player_win=1, dealer_win=0.
REQ-033 Four cards, pscore=7, dscore=7 -> no third cards, DONE, player_win=dealer_win=1.
REQ-034 pscore=3, dscore=6, pcard3 loaded as 7 -> DECIDE_D->DEAL_D3; step loads dcard3; pcard3=12 instead -> DONE, dcard3=0.
REQ-035 Step pulses during DECIDE_P/DECIDE_D -> no register changes; step in DONE -> all cards 0, DEAL_P1.
REQ-036 reset asserted in DEAL_P3 together with step -> pcard3 stays 0, all cards 0, state DEAL_P1.

Source files
------------

// File: rtl/baccarat_dealer_pkg.sv
// Shared state encoding and card/score constants for the baccarat dealer.
package baccarat_dealer_pkg;

  typedef enum logic [3:0] {
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    DECIDE_P,
    DEAL_P3,
    DECIDE_D,
    DEAL_D3,
    DONE
  } state_t;

  localparam logic [3:0] CARD_NONE        = 4'd0;
  localparam logic [3:0] CARD_MIN         = 4'd1;
  localparam logic [3:0] CARD_MAX         = 4'd13;
  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

endpackage

// File: rtl/baccarat_dealer_deal_card.sv
// Free-running card source: cycles A..K (1..13) every clock, independent of play.
module deal_card
  import baccarat_dealer_pkg::*;
(
  input  logic       slow_clock,
  input  logic       reset,
  output logic [3:0] card
);

  // Out-of-range values also fold back to ace so the source always recovers.
  always_ff @(posedge slow_clock) begin
    if (reset)
      card <= CARD_MIN;
    else if (card >= CARD_MAX)
      card <= CARD_MIN;
    else
      card <= card + 4'd1;
  end

endmodule

// File: rtl/baccarat_dealer.sv
// Baccarat dealing sequencer: deals the four opening cards on step, applies the
// third-card rules against external hand scores and reports the winner.
module baccarat_dealer
  import baccarat_dealer_pkg::*;
(
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win
);

  state_t     state, next_state;
  logic [3:0] card;
  logic       load_p1, load_p2, load_p3, load_d1, load_d2, load_d3;
  logic       clear_all;

  deal_card u_deal_card (
    .slow_clock (slow_clock),
    .reset      (reset),
    .card       (card)
  );

  function automatic logic [3:0] third_card_value(input logic [3:0] c);
    logic [3:0] v;
    v = (c >= 4'd10) ? 4'd0 : c;
    return v;
  endfunction

  // Banker's draw rule, keyed on the dealer total and the player's third card.
  function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] v);
    logic draw;
    case (ds)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

  always_ff @(posedge slow_clock) begin
    if (reset)
      state <= DEAL_P1;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_p1    = 1'b0;
    load_p2    = 1'b0;
    load_p3    = 1'b0;
    load_d1    = 1'b0;
    load_d2    = 1'b0;
    load_d3    = 1'b0;
    clear_all  = 1'b0;
    case (state)
      DEAL_P1: if (step) begin load_p1 = 1'b1; next_state = DEAL_D1; end
      DEAL_D1: if (step) begin load_d1 = 1'b1; next_state = DEAL_P2; end
      DEAL_P2: if (step) begin load_p2 = 1'b1; next_state = DEAL_D2; end
      DEAL_D2: if (step) begin load_d2 = 1'b1; next_state = DECIDE_P; end
      DECIDE_P: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN))
          next_state = DONE;
        else if (pscore < PLAYER_STAND_MIN)
          next_state = DEAL_P3;
        else if (dscore < PLAYER_STAND_MIN)
          next_state = DEAL_D3;
        else
          next_state = DONE;
      end
      DEAL_P3: if (step) begin load_p3 = 1'b1; next_state = DECIDE_D; end
      DECIDE_D: begin
        if (dealer_draws(dscore, third_card_value(pcard3)))
          next_state = DEAL_D3;
        else
          next_state = DONE;
      end
      DEAL_D3: if (step) begin load_d3 = 1'b1; next_state = DONE; end
      DONE: if (step) begin clear_all = 1'b1; next_state = DEAL_P1; end
      default: next_state = DEAL_P1;
    endcase
  end

  // Reset outranks everything, so a round interrupted mid-deal leaves no partial card.
  always_ff @(posedge slow_clock) begin
    if (reset || clear_all) begin
      pcard1 <= CARD_NONE;
      pcard2 <= CARD_NONE;
      pcard3 <= CARD_NONE;
      dcard1 <= CARD_NONE;
      dcard2 <= CARD_NONE;
      dcard3 <= CARD_NONE;
    end else begin
      if (load_p1) pcard1 <= card;
      if (load_p2) pcard2 <= card;
      if (load_p3) pcard3 <= card;
      if (load_d1) dcard1 <= card;
      if (load_d2) dcard2 <= card;
      if (load_d3) dcard3 <= card;
    end
  end

  assign done       = (state == DONE);
  assign player_win = done && (pscore >= dscore);
  assign dealer_win = done && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_dealer.sv
// Scoreboard bench for baccarat_dealer: dealt cards are predicted from a model
// of the card source and checked as each load edge completes.
module tb_baccarat_dealer;
  import baccarat_dealer_pkg::*;

  logic       slow_clock = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b0;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic       done, player_win, dealer_win;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] value;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] src_model;
  logic [3:0] snap [6];

  baccarat_dealer dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .step       (step),
    .pscore     (pscore),
    .dscore     (dscore),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .done       (done),
    .player_win (player_win),
    .dealer_win (dealer_win)
  );

  always #5 slow_clock = ~slow_clock;

  // Reference card source: 1..13 repeating, forced to 1 by reset.
  always @(posedge slow_clock) begin
    if (reset)
      src_model <= 4'd1;
    else if (src_model == 4'd13)
      src_model <= 4'd1;
    else
      src_model <= src_model + 4'd1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] get_card(input int idx);
    case (idx)
      0:       return pcard1;
      1:       return pcard2;
      2:       return pcard3;
      3:       return dcard1;
      4:       return dcard2;
      default: return dcard3;
    endcase
  endfunction

  task automatic take_snapshot();
    for (int i = 0; i < 6; i++) snap[i] = get_card(i);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge slow_clock);
  endtask

  task automatic wait_source(input logic [3:0] want);
    int budget;
    budget = 0;
    while (src_model !== want && budget < 20) begin
      @(negedge slow_clock);
      budget++;
    end
    if (src_model !== want) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait_source: got %0d required %0d", src_model, want);
    end
  endtask

  // Pulse step for one edge; the scoreboard entry is popped once the load edge has passed.
  task automatic deal_step(input int idx, input string tag);
    exp_t e;
    e.idx   = idx[2:0];
    e.value = src_model;
    sb.push_back(e);
    step = 1'b1;
    @(negedge slow_clock);
    step = 1'b0;
    e = sb.pop_front();
    tests_run++;
    if (get_card(int'(e.idx)) !== e.value) begin
      tests_failed++;
      $display("[TB] FAIL deal_%s: got %0d required %0d", tag, get_card(int'(e.idx)), e.value);
    end
  endtask

  task automatic deal_four();
    idle($urandom_range(0, 2)); deal_step(0, "pcard1");
    idle($urandom_range(0, 2)); deal_step(3, "dcard1");
    idle($urandom_range(0, 2)); deal_step(1, "pcard2");
    idle($urandom_range(0, 2)); deal_step(4, "dcard2");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step  = 1'b1;
    idle(3);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (get_card(i) !== 4'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_card%0d: got %0d required 0", i, get_card(i));
      end
    end
    tests_run++;
    if (dut.state !== DEAL_P1) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %0d required %0d", dut.state, DEAL_P1);
    end
    tests_run++;
    if ({done, player_win, dealer_win} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b required 000", {done, player_win, dealer_win});
    end
    tests_run++;
    if (dut.u_deal_card.card !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL reset_source: got %0d required 1", dut.u_deal_card.card);
    end
    reset = 1'b0;
    step  = 1'b0;
  endtask

  task automatic test_first_card();
    wait_source(4'd3);
    deal_step(0, "first_pcard1");
    tests_run++;
    if (pcard1 !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL first_card_value: got %0d required 3", pcard1);
    end
    for (int i = 1; i < 6; i++) begin
      tests_run++;
      if (get_card(i) !== 4'd0) begin
        tests_failed++;
        $display("[TB] FAIL first_card_other%0d: got %0d required 0", i, get_card(i));
      end
    end
    tests_run++;
    if (dut.state !== DEAL_D1) begin
      tests_failed++;
      $display("[TB] FAIL first_card_state: got %0d required %0d", dut.state, DEAL_D1);
    end
  endtask

  task automatic test_natural();
    pscore = 4'd9;
    dscore = 4'd4;
    deal_step(3, "nat_dcard1");
    deal_step(1, "nat_pcard2");
    deal_step(4, "nat_dcard2");
    tests_run++;
    if (dut.state !== DECIDE_P) begin
      tests_failed++;
      $display("[TB] FAIL natural_decide: got %0d required %0d", dut.state, DECIDE_P);
    end
    idle(1);
    tests_run++;
    if (dut.state !== DONE || done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL natural_done: got state %0d done %b required state %0d done 1", dut.state, done, DONE);
    end
    tests_run++;
    if (pcard3 !== 4'd0 || dcard3 !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL natural_third: got %0d/%0d required 0/0", pcard3, dcard3);
    end
    tests_run++;
    if (player_win !== 1'b1 || dealer_win !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL natural_win: got %b%b required 10", player_win, dealer_win);
    end
  endtask

  task automatic test_done_clear();
    step = 1'b1;
    @(negedge slow_clock);
    step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (get_card(i) !== 4'd0) begin
        tests_failed++;
        $display("[TB] FAIL clear_card%0d: got %0d required 0", i, get_card(i));
      end
    end
    tests_run++;
    if (dut.state !== DEAL_P1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear_state: got state %0d done %b required state %0d done 0", dut.state, done, DEAL_P1);
    end
  endtask

  task automatic test_tie();
    pscore = 4'd7;
    dscore = 4'd7;
    deal_four();
    idle(1);
    tests_run++;
    if (dut.state !== DONE) begin
      tests_failed++;
      $display("[TB] FAIL tie_state: got %0d required %0d", dut.state, DONE);
    end
    tests_run++;
    if (pcard3 !== 4'd0 || dcard3 !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL tie_third: got %0d/%0d required 0/0", pcard3, dcard3);
    end
    tests_run++;
    if (player_win !== 1'b1 || dealer_win !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL tie_win: got %b%b required 11", player_win, dealer_win);
    end
    test_done_clear();
  endtask

  task automatic test_third_cards();
    pscore = 4'd3;
    dscore = 4'd6;
    deal_four();
    take_snapshot();
    step = 1'b1;
    @(negedge slow_clock);
    step = 1'b0;
    tests_run++;
    if (dut.state !== DEAL_P3) begin
      tests_failed++;
      $display("[TB] FAIL third_to_p3: got %0d required %0d", dut.state, DEAL_P3);
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (get_card(i) !== snap[i]) begin
        tests_failed++;
        $display("[TB] FAIL decide_p_step_card%0d: got %0d required %0d", i, get_card(i), snap[i]);
      end
    end
    wait_source(4'd7);
    deal_step(2, "pcard3_seven");
    tests_run++;
    if (dut.state !== DECIDE_D) begin
      tests_failed++;
      $display("[TB] FAIL third_decide_d: got %0d required %0d", dut.state, DECIDE_D);
    end
    take_snapshot();
    step = 1'b1;
    @(negedge slow_clock);
    step = 1'b0;
    tests_run++;
    if (dut.state !== DEAL_D3) begin
      tests_failed++;
      $display("[TB] FAIL third_to_d3: got %0d required %0d", dut.state, DEAL_D3);
    end
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (get_card(i) !== snap[i]) begin
        tests_failed++;
        $display("[TB] FAIL decide_d_step_card%0d: got %0d required %0d", i, get_card(i), snap[i]);
      end
    end
    deal_step(5, "dcard3");
    tests_run++;
    if (dut.state !== DONE || player_win !== 1'b0 || dealer_win !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL third_result: got state %0d win %b%b required state %0d win 01", dut.state, player_win, dealer_win, DONE);
    end
    test_done_clear();

    deal_four();
    idle(1);
    wait_source(4'd12);
    deal_step(2, "pcard3_queen");
    idle(1);
    tests_run++;
    if (dut.state !== DONE || dcard3 !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL queen_stand: got state %0d dcard3 %0d required state %0d dcard3 0", dut.state, dcard3, DONE);
    end
    test_done_clear();
  endtask

  task automatic test_reset_mid_round();
    pscore = 4'd2;
    dscore = 4'd2;
    deal_four();
    idle(1);
    tests_run++;
    if (dut.state !== DEAL_P3) begin
      tests_failed++;
      $display("[TB] FAIL midreset_pre: got %0d required %0d", dut.state, DEAL_P3);
    end
    reset = 1'b1;
    step  = 1'b1;
    @(negedge slow_clock);
    reset = 1'b0;
    step  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (get_card(i) !== 4'd0) begin
        tests_failed++;
        $display("[TB] FAIL midreset_card%0d: got %0d required 0", i, get_card(i));
      end
    end
    tests_run++;
    if (dut.state !== DEAL_P1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_state: got state %0d done %b required state %0d done 0", dut.state, done, DEAL_P1);
    end
  endtask

  // Random rounds judged by a bench-side rule table indexed by the third card value.
  task automatic test_back_to_back();
    state_t     exp_state;
    logic [3:0] ps, ds, p3, v;
    logic [9:0] mask;
    for (int r = 0; r < 8; r++) begin
      ps = 4'($urandom_range(0, 9));
      ds = 4'($urandom_range(0, 9));
      pscore = ps;
      dscore = ds;
      deal_four();
      if (ps >= 4'd8 || ds >= 4'd8) exp_state = DONE;
      else if (ps <= 4'd5)          exp_state = DEAL_P3;
      else if (ds <= 4'd5)          exp_state = DEAL_D3;
      else                          exp_state = DONE;
      idle(1);
      tests_run++;
      if (dut.state !== exp_state) begin
        tests_failed++;
        $display("[TB] FAIL round%0d_decide_p: got %0d required %0d (p=%0d d=%0d)", r, dut.state, exp_state, ps, ds);
      end
      if (exp_state == DEAL_P3) begin
        idle($urandom_range(0, 12));
        p3 = src_model;
        deal_step(2, "round_pcard3");
        v = (p3 >= 4'd10) ? 4'd0 : p3;
        case (ds)
          4'd0, 4'd1, 4'd2: mask = 10'b11_1111_1111;
          4'd3:             mask = 10'b10_1111_1111;
          4'd4:             mask = 10'b00_1111_1100;
          4'd5:             mask = 10'b00_1111_0000;
          4'd6:             mask = 10'b00_1100_0000;
          default:          mask = 10'b00_0000_0000;
        endcase
        exp_state = mask[v] ? DEAL_D3 : DONE;
        idle(1);
        tests_run++;
        if (dut.state !== exp_state) begin
          tests_failed++;
          $display("[TB] FAIL round%0d_decide_d: got %0d required %0d (d=%0d v=%0d)", r, dut.state, exp_state, ds, v);
        end
      end
      if (exp_state == DEAL_D3) deal_step(5, "round_dcard3");
      tests_run++;
      if (done !== 1'b1 || player_win !== (ps >= ds) || dealer_win !== (ds >= ps)) begin
        tests_failed++;
        $display("[TB] FAIL round%0d_result: got done %b win %b%b required done 1 win %b%b",
                 r, done, player_win, dealer_win, ps >= ds, ds >= ps);
      end
      test_done_clear();
    end
  endtask

  initial begin
    test_reset();
    test_first_card();
    test_natural();
    test_done_clear();
    test_tie();
    test_third_cards();
    test_reset_mid_round();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
